// File: rtl/control_pipeline_if.sv
// Bundle between the instruction decoder (master) and the control pipeline (slave):
// the decoded ID-stage word in, stage control fields, hazard stall and forwarding selects out.
interface control_pipeline_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       controlIn;
  logic [1:0]       compareCode;
  logic [1:0]       branchSrc;
  logic [4:0]       rsId;
  logic [4:0]       rtId;
  logic [4:0]       rdId;
  logic             stall;
  logic [2:0]       exCtrl;
  logic [1:0]       memCtrl;
  logic [2:0]       wbCtrl;
  logic [4:0]       destMem;
  logic [4:0]       destWb;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output controlIn, compareCode, branchSrc, rsId, rtId, rdId,
    input  stall, exCtrl, memCtrl, wbCtrl, destMem, destWb, forwardA, forwardB, stallCount
  );

  modport slave (
    input  controlIn, compareCode, branchSrc, rsId, rtId, rdId,
    output stall, exCtrl, memCtrl, wbCtrl, destMem, destWb, forwardA, forwardB, stallCount
  );
endinterface

// File: rtl/control_pipeline.sv
// EX/MEM/WB control pipeline: carries decoder control fields, detects load-use and
// branch-operand hazards (stall + bubble), drives EX forwarding and counts stall cycles.
module control_pipeline #(
  parameter int          CNT_W  = 16,
  parameter int unsigned RA_REG = 31
) (
  input  logic               clock,
  input  logic               reset,
  control_pipeline_if.slave  bus
);

  localparam logic [4:0] RaReg = RA_REG[4:0];

  // EX stage keeps the whole decoder word; later stages keep only what they still need.
  logic [7:0]       exCtrlQ;
  logic [4:0]       destEx;
  logic [4:0]       rsEx;
  logic [4:0]       rtEx;
  logic             memReadM;
  logic             memWriteM;
  logic             regWriteM;
  logic [1:0]       regSrcM;
  logic [4:0]       destM;
  logic             regWriteW;
  logic [1:0]       regSrcW;
  logic [4:0]       destW;
  logic [CNT_W-1:0] cnt;

  logic [4:0] destId;
  logic       exMemRead;
  logic       exRegWrite;
  logic       loadUse;
  logic       branchActive;
  logic       useRt;
  logic       exMatch;
  logic       memMatch;
  logic       branchHazard;
  logic       stallInt;

  always_comb begin
    destId = '0;
    case (bus.controlIn[6:5])
      2'b00:   destId = bus.rdId;
      2'b01:   destId = bus.rtId;
      2'b10:   destId = RaReg;
      default: destId = '0;
    endcase
  end

  assign exMemRead  = exCtrlQ[4];
  assign exRegWrite = exCtrlQ[2];

  // rt is compared even for instructions that do not read it; a spare stall is harmless.
  assign loadUse = exMemRead && (destEx != 5'd0) &&
                   ((destEx == bus.rsId) || (destEx == bus.rtId));

  // Branches resolve in ID, so their operands must already be in the register file or
  // on a forwardable path; an unresolved load in MEM still blocks them.
  assign branchActive = (bus.compareCode != 2'b00) && (bus.branchSrc != 2'b01);
  assign useRt        = (bus.compareCode == 2'b01) || (bus.compareCode == 2'b10);
  assign exMatch      = (destEx == bus.rsId) || (useRt && (destEx == bus.rtId));
  assign memMatch     = (destM == bus.rsId) || (useRt && (destM == bus.rtId));
  assign branchHazard = branchActive &&
                        ((exRegWrite && (destEx != 5'd0) && exMatch) ||
                         (memReadM && (destM != 5'd0) && memMatch));

  assign stallInt = reset && (loadUse || branchHazard);

  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic       memWr,
    input logic [4:0] memDst,
    input logic       wbWr,
    input logic [4:0] wbDst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (memWr && (memDst != 5'd0) && (memDst == src))
      sel = 2'b10;
    else if (wbWr && (wbDst != 5'd0) && (wbDst == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exCtrlQ   <= '0;
      destEx    <= '0;
      rsEx      <= '0;
      rtEx      <= '0;
      memReadM  <= 1'b0;
      memWriteM <= 1'b0;
      regWriteM <= 1'b0;
      regSrcM   <= '0;
      destM     <= '0;
      regWriteW <= 1'b0;
      regSrcW   <= '0;
      destW     <= '0;
      cnt       <= '0;
    end else begin
      if (stallInt) begin
        exCtrlQ <= '0;
        destEx  <= '0;
        rsEx    <= '0;
        rtEx    <= '0;
      end else begin
        exCtrlQ <= bus.controlIn;
        destEx  <= destId;
        rsEx    <= bus.rsId;
        rtEx    <= bus.rtId;
      end
      memReadM  <= exCtrlQ[4];
      memWriteM <= exCtrlQ[3];
      regWriteM <= exCtrlQ[2];
      regSrcM   <= exCtrlQ[1:0];
      destM     <= destEx;
      regWriteW <= regWriteM;
      regSrcW   <= regSrcM;
      destW     <= destM;
      if (stallInt && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.stall      = stallInt;
  assign bus.exCtrl     = exCtrlQ[7:5];
  assign bus.memCtrl    = {memReadM, memWriteM};
  assign bus.wbCtrl     = {regWriteW, regSrcW};
  assign bus.destMem    = destM;
  assign bus.destWb     = destW;
  assign bus.forwardA   = fwdSel(rsEx, regWriteM, destM, regWriteW, destW);
  assign bus.forwardB   = fwdSel(rtEx, regWriteM, destM, regWriteW, destW);
  assign bus.stallCount = cnt;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: reset, latency, load-use, branch-after-load,
// forwarding priority, jumps, reset mid-stall and counter saturation (CNT_W=4 copy).
module tb_control_pipeline;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] NOP  = 8'b0_00_00_0_00;
  localparam logic [7:0] ADDI = 8'b1_01_00_1_00;
  localparam logic [7:0] LW   = 8'b1_01_10_1_01;
  localparam logic [7:0] ADD  = 8'b0_00_00_1_00;
  localparam logic [7:0] JAL  = 8'b0_10_00_1_10;

  always #5 clock = ~clock;

  control_pipeline_if #(.CNT_W(16)) bus();
  control_pipeline_if #(.CNT_W(4))  satBus();

  control_pipeline #(.CNT_W(16), .RA_REG(31)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  control_pipeline #(.CNT_W(4), .RA_REG(31)) satDut (
    .clock (clock),
    .reset (reset),
    .bus   (satBus.slave)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setId(input logic [7:0] c, input logic [1:0] cc, input logic [1:0] bs,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.controlIn   = c;
    bus.compareCode = cc;
    bus.branchSrc   = bs;
    bus.rsId        = rs;
    bus.rtId        = rt;
    bus.rdId        = rd;
    #1;
  endtask

  task automatic setSatId(input logic [7:0] c, input logic [1:0] cc, input logic [1:0] bs,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    satBus.controlIn   = c;
    satBus.compareCode = cc;
    satBus.branchSrc   = bs;
    satBus.rsId        = rs;
    satBus.rtId        = rt;
    satBus.rdId        = rd;
  endtask

  task automatic doReset();
    reset = 1'b0;
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.controlIn   = 8'($urandom_range(0, 255));
    bus.compareCode = 2'($urandom_range(0, 3));
    bus.branchSrc   = 2'($urandom_range(0, 2));
    bus.rsId        = 5'($urandom_range(0, 31));
    bus.rtId        = 5'($urandom_range(0, 31));
    bus.rdId        = 5'($urandom_range(0, 31));
    tick();
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
    checks++; if ({bus.exCtrl, bus.memCtrl, bus.wbCtrl} !== 8'd0) begin errors++; $display("FAIL rst_ctrl got %h exp 00", {bus.exCtrl, bus.memCtrl, bus.wbCtrl}); end
    checks++; if ({bus.destMem, bus.destWb} !== 10'd0) begin errors++; $display("FAIL rst_dest got %h exp 000", {bus.destMem, bus.destWb}); end
    checks++; if ({bus.forwardA, bus.forwardB} !== 4'd0) begin errors++; $display("FAIL rst_fwd got %h exp 0", {bus.forwardA, bus.forwardB}); end
    checks++; if (bus.stallCount !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.stallCount); end
    reset = 1'b1;
    setId(ADDI, 2'b00, 2'b00, 5'd2, 5'd5, 5'd0);
    tick();
    checks++; if (bus.exCtrl !== 3'b101) begin errors++; $display("FAIL addi_ex got %b exp 101", bus.exCtrl); end
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if (bus.memCtrl !== 2'b00) begin errors++; $display("FAIL addi_mem got %b exp 00", bus.memCtrl); end
    checks++; if (bus.destMem !== 5'd5) begin errors++; $display("FAIL addi_destmem got %0d exp 5", bus.destMem); end
    tick();
    checks++; if (bus.wbCtrl !== 3'b100) begin errors++; $display("FAIL addi_wb got %b exp 100", bus.wbCtrl); end
    checks++; if (bus.destWb !== 5'd5) begin errors++; $display("FAIL addi_destwb got %0d exp 5", bus.destWb); end
  endtask

  task automatic test_load_use();
    doReset();
    setId(LW, 2'b00, 2'b00, 5'd1, 5'd8, 5'd0);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_pre got %b exp 0", bus.stall); end
    tick();
    setId(ADD, 2'b00, 2'b00, 5'd8, 5'd2, 5'd10);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", bus.stall); end
    tick();
    checks++; if (bus.exCtrl !== 3'b000) begin errors++; $display("FAIL lu_bubble got %b exp 000", bus.exCtrl); end
    checks++; if (bus.memCtrl !== 2'b10) begin errors++; $display("FAIL lu_memrd got %b exp 10", bus.memCtrl); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", bus.stall); end
    tick();
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    checks++; if (bus.forwardA !== 2'b01) begin errors++; $display("FAIL lu_fwda got %b exp 01", bus.forwardA); end
    checks++; if (bus.forwardB !== 2'b00) begin errors++; $display("FAIL lu_fwdb got %b exp 00", bus.forwardB); end
    checks++; if (bus.wbCtrl !== 3'b101) begin errors++; $display("FAIL lu_wb got %b exp 101", bus.wbCtrl); end
    checks++; if (bus.stallCount !== 16'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", bus.stallCount); end
  endtask

  task automatic test_branch_after_load();
    doReset();
    setId(LW, 2'b00, 2'b00, 5'd1, 5'd9, 5'd0);
    tick();
    setId(NOP, 2'b01, 2'b00, 5'd9, 5'd4, 5'd0);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL br_stall1 got %b exp 1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL br_stall2 got %b exp 1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL br_release got %b exp 0", bus.stall); end
    checks++; if (bus.stallCount !== 16'd2) begin errors++; $display("FAIL br_count got %0d exp 2", bus.stallCount); end
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_forward_priority();
    doReset();
    setId(ADD, 2'b00, 2'b00, 5'd1, 5'd2, 5'd3);
    tick();
    setId(ADD, 2'b00, 2'b00, 5'd1, 5'd2, 5'd3);
    tick();
    setId(ADD, 2'b00, 2'b00, 5'd3, 5'd3, 5'd4);
    tick();
    checks++; if (bus.forwardA !== 2'b10) begin errors++; $display("FAIL fp_fwda got %b exp 10", bus.forwardA); end
    checks++; if (bus.forwardB !== 2'b10) begin errors++; $display("FAIL fp_fwdb got %b exp 10", bus.forwardB); end
    doReset();
    setId(ADD, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0);
    tick();
    setId(ADD, 2'b00, 2'b00, 5'd1, 5'd2, 5'd0);
    tick();
    setId(ADD, 2'b00, 2'b00, 5'd0, 5'd0, 5'd4);
    tick();
    checks++; if ({bus.forwardA, bus.forwardB} !== 4'b0000) begin errors++; $display("FAIL fp_zero got %b exp 0000", {bus.forwardA, bus.forwardB}); end
  endtask

  task automatic test_jump();
    doReset();
    setId(ADD, 2'b00, 2'b00, 5'd1, 5'd2, 5'd7);
    tick();
    setId(NOP, 2'b11, 2'b01, 5'd7, 5'd0, 5'd0);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL j_nostall got %b exp 0", bus.stall); end
    setId(NOP, 2'b11, 2'b10, 5'd7, 5'd0, 5'd0);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL jr_stall got %b exp 1", bus.stall); end
    setId(JAL, 2'b11, 2'b01, 5'd0, 5'd0, 5'd0);
    tick();
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    checks++; if (bus.destWb !== 5'd31) begin errors++; $display("FAIL jal_dest got %0d exp 31", bus.destWb); end
    checks++; if (bus.wbCtrl !== 3'b110) begin errors++; $display("FAIL jal_wb got %b exp 110", bus.wbCtrl); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    setId(LW, 2'b00, 2'b00, 5'd1, 5'd8, 5'd0);
    tick();
    setId(LW, 2'b00, 2'b00, 5'd8, 5'd8, 5'd0);
    tick();
    tick();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rm_prestall got %b exp 1", bus.stall); end
    checks++; if (bus.stallCount !== 16'd1) begin errors++; $display("FAIL rm_precount got %0d exp 1", bus.stallCount); end
    reset = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b exp 0", bus.stall); end
    checks++; if ({bus.exCtrl, bus.wbCtrl} !== 6'd0) begin errors++; $display("FAIL rm_ctrl got %b exp 000000", {bus.exCtrl, bus.wbCtrl}); end
    checks++; if (bus.stallCount !== 16'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", bus.stallCount); end
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    doReset();
    setSatId(LW, 2'b01, 2'b00, 5'd8, 5'd8, 5'd0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (satBus.stallCount !== 4'd4) begin errors++; $display("FAIL sat_early got %0d exp 4", satBus.stallCount); end
    for (int i = 0; i < 40; i++) tick();
    checks++; if (satBus.stallCount !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", satBus.stallCount); end
    setSatId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    setSatId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    setId(NOP, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_forward_priority();
    test_jump();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Consumer end of the instruction decoder's control word.
- Takes the decoded 8-bit control word, compareCode and branchSrc in ID and carries the control fields through the EX, MEM and WB pipeline registers.
- Detects load-use and branch-operand hazards. On a hazard it stalls the front end and inserts bubbles.
- Generates EX-stage forwarding selects and keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.
- RA_REG, 31, register index written when RegDest selects the return-address register.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- controlIn  in  8  decoder word. [7] AluSrc, [6:5] RegDest, [4] MemRead, [3] MemWrite, [2] RegWrite, [1:0] RegSrc.
- compareCode  in  2  00 none, 01 beq, 10 bne, 11 j/jal/jr.
- branchSrc  in  2  00 pc+4+imm, 01 imm26, 10 register rs.
- rsId, rtId, rdId  in  5 each  register fields of the instruction in ID.
- stall  out  1  hold PC and IF/ID this cycle.
- exCtrl  out  3  {AluSrc, RegDest} of the instruction in EX.
- memCtrl  out  2  {MemRead, MemWrite} of the instruction in MEM.
- wbCtrl  out  3  {RegWrite, RegSrc} of the instruction in WB.
- destMem, destWb  out  5 each  destination register in MEM and WB.
- forwardA, forwardB  out  2 each  EX operand select. 00 register file, 10 from MEM, 01 from WB.
- stallCount  out  CNT_W  number of stall cycles since reset.

Behaviour:
- Destination decode in ID from RegDest:
  - 00 -> rdId
  - 01 -> rtId
  - 10 -> RA_REG
  - 11 -> 0 (no write)
- Reset (reset=0, asynchronous):
  - All stage registers clear: control, dest, rsEx, rtEx.
  - All outputs read 0; stallCount = 0.
  - While reset is held, stall = 0.
  - Reset asserted mid-stall discards the pending instruction's bubble state.
- Pipeline advance, every rising edge with reset=1:
  - WB <= MEM, MEM <= EX.
  - EX <= ID when stall=0, else EX <= bubble (all-zero control, dest 0, rsEx/rtEx 0).
  - MEM and WB always advance; a stall never freezes them.
- Latency: a control word presented in ID appears on exCtrl 1 cycle later, memCtrl 2 cycles later, wbCtrl 3 cycles later.
- stall is combinational from the current stage registers and the ID inputs. It is asserted in the same cycle the hazard exists.
- Load-use hazard: stall=1 if all of the following hold:
  - EX MemRead=1
  - EX dest != 0
  - EX dest == rsId or EX dest == rtId (conservative: both always compared)
- Branch-operand hazard: applies when compareCode != 00 and branchSrc != 01. Operands are rs, plus rt when compareCode is 01 or 10. stall=1 if either holds:
  - EX RegWrite=1, EX dest != 0, and EX dest matches an operand.
  - MEM MemRead=1, destMem != 0, and destMem matches an operand.
- A plain j (compareCode=11, branchSrc=01) never stalls.
- Simultaneous hazards are OR-ed; a single stall signal covers both.
- Repeated stalls: a hazard persists until its producer leaves the matching stage.
  - Load followed by a dependent beq: stall 2 cycles.
  - Load followed by a dependent ALU op: stall 1 cycle.
- Forwarding, evaluated for rsEx (forwardA) and rtEx (forwardB):
  - If MEM RegWrite=1, destMem != 0 and destMem == operand -> 10.
  - Else if WB RegWrite=1, destWb != 0 and destWb == operand -> 01.
  - Else 00.
  - When both MEM and WB match, MEM wins.
  - Register 0 never forwards.
- stallCount: increments on each rising edge where stall=1. It saturates at 2^CNT_W-1 and does not wrap.

Test Plan:
- Reset check: hold reset=0 with random inputs -> all outputs 0, stall=0, stallCount=0. Release reset, present addi word (controlIn=8'b1_01_00_1_00, rtId=5) -> exCtrl=3'b101 after 1 cycle, memCtrl=0 after 2, wbCtrl=3'b100 and destWb=5 after 3.
- Load-use: lw to $8 in ID, then add rs=$8 -> stall=1 for exactly 1 cycle; EX receives a bubble (exCtrl=0); next cycle the add enters EX with forwardA=01 (lw now in WB); stallCount=1.
- Branch after load: lw $9, then beq rs=$9 -> stall=1 for 2 consecutive cycles, then 0; stallCount=2.
- Forward priority: add $3 followed by add $3 followed by sub rs=$3,rt=$3 -> in EX, forwardA=forwardB=10. Destination $0 on the producers -> both 00.
- Jump and jal: j (compareCode=11, branchSrc=01) with EX writing rs -> stall=0. jal (RegDest=10) -> destWb=31 after 3 cycles with RegSrc=10.
- Reset mid-stall, then saturation: assert reset during a load-use stall -> outputs 0 immediately without a clock edge. Separately, force CNT_W=4 and hold a hazard 20 cycles -> stallCount stops at 15.
